sample_debouncer: RTL and testbench



---
 rtl/board_io_pkg.sv | 14 +
 rtl/sample_debouncer_tick_edge.sv | 27 ++
 rtl/sample_debouncer.sv | 142 ++++++++++++++
 tb/tb_sample_debouncer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared definitions for board pin-input blocks: debouncer state encoding and
// the default synchroniser depth.
package board_io_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_TO_HIGH = 2'd1,
        S_HIGH    = 2'd2,
        S_TO_LOW  = 2'd3
    } db_state_e;

    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sample_debouncer_tick_edge.sv
// Turns the divider's square wave into a one-clk sample strobe on each rising edge.
module tick_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic samp
);

    logic tick_q;
    logic tick_d;

    always_comb begin
        tick_d = tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // tick_q clears in reset, so a tick already high at release strobes at once.
    assign samp = tick & ~tick_q;

endmodule

// File: rtl/sample_debouncer.sv
// Debounces a raw button level by sampling it on divider ticks; a level change is
// committed only after STABLE_SAMPLES consecutive agreeing samples.
module sample_debouncer
    import board_io_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SAMPLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sin;
    logic                   samp;

    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          cnt_inc;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = in;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    assign sin = sync_q[SYNC_STAGES-1];

    tick_edge u_tick_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .samp  (samp)
    );

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (samp) begin
            unique case (state_q)
                S_LOW: begin
                    if (sin) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = S_HIGH;
                            cnt_d   = '0;
                            out_d   = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = S_TO_HIGH;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_TO_HIGH: begin
                    if (!sin) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        out_d   = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                S_HIGH: begin
                    if (!sin) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_d = S_LOW;
                            cnt_d   = '0;
                            out_d   = 1'b0;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = S_TO_LOW;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_TO_LOW: begin
                    if (sin) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        out_d   = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_sample_debouncer.sv
// Bench for sample_debouncer: table of sample patterns, hand-built corner cases and
// random input runs checked every cycle against a run-length reference model.
module tb_sample_debouncer;

    localparam int SS = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic tick;
    logic din;
    logic out, rise, fall;

    logic [1:0] div = 2'd0;
    logic       div_en = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div_en) div <= div + 2'd1;
    end
    assign tick = div[1];

    sample_debouncer #(
        .STABLE_SAMPLES (SS),
        .SYNC_STAGES    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .in    (din),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    // Reference: count consecutive samples disagreeing with the output level;
    // the level flips once that run reaches SS.
    typedef struct packed {
        logic       o;
        logic       r;
        logic       f;
        logic [7:0] run;
    } mres_t;

    function automatic mres_t model_next(input logic smp, input logic s,
                                         input logic o, input logic [7:0] run);
        mres_t n;
        n.o = o;
        n.r = 1'b0;
        n.f = 1'b0;
        n.run = run;
        if (smp) begin
            if (s != o) begin
                n.run = run + 8'd1;
                if (int'(n.run) == SS) begin
                    n.o   = ~o;
                    n.r   = ~o;
                    n.f   = o;
                    n.run = 8'd0;
                end
            end else begin
                n.run = 8'd0;
            end
        end
        return n;
    endfunction

    logic  m_s1 = 1'b0, m_s2 = 1'b0, m_tq = 1'b0;
    mres_t m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1  <= 1'b0;
            m_s2  <= 1'b0;
            m_tq  <= 1'b0;
            m_res <= '0;
        end else begin
            m_res <= model_next(tick & ~m_tq, m_s2, m_res.o, m_res.run);
            m_s1  <= din;
            m_s2  <= m_s1;
            m_tq  <= tick;
        end
    end

    typedef struct {
        logic [15:0] pat;
        int          n;
        logic        exp_out;
        int          exp_rise;
        int          exp_fall;
    } vec_t;

    vec_t vt[8];

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("cyc_out", out, m_res.o);
        check("cyc_rise", rise, m_res.r);
        check("cyc_fall", fall, m_res.f);
        check("cyc_not_both", rise & fall, 0);
        if (rise) rise_cnt++;
        if (fall) fall_cnt++;
    endtask

    initial begin
        int n, rb, fb, len;

        vt[0] = '{16'h000F, 4,  1'b1, 1, 0};
        vt[1] = '{16'h0000, 4,  1'b0, 0, 1};
        vt[2] = '{16'h36DB, 15, 1'b0, 0, 0};
        vt[3] = '{16'h000F, 4,  1'b1, 1, 0};
        vt[4] = '{16'h000C, 4,  1'b1, 0, 0};
        vt[5] = '{16'h0000, 3,  1'b0, 0, 1};
        vt[6] = '{16'h001B, 6,  1'b0, 0, 0};
        vt[7] = '{16'h0007, 3,  1'b1, 1, 0};

        rst_n = 1'b0;
        din   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("reset_out", out, 0);
            check("reset_rise", rise, 0);
            check("reset_fall", fall, 0);
        end
        $display("reset hold: out=%0b", out);

        rst_n = 1'b1;
        repeat (20) step();
        check("release_out", out, 1);
        @(posedge clk);
        #1 check("pre_async_out", out, 1);
        #1 rst_n = 1'b0;
        #1 check("async_out", out, 0);
        $display("async reset: out=%0b", out);
        din = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();

        din = 1'b1;
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (rise) begin
                n = i;
                break;
            end
        end
        check_rng("press_latency", n, 11, 15);
        step();
        check("press_rise_width", rise, 0);
        check("press_out", out, 1);
        rb = rise_cnt;
        repeat (20) step();
        check("press_no_extra_rise", rise_cnt - rb, 0);
        $display("clean press: latency=%0d out=%0b", n, out);

        din = 1'b0;
        fb = fall_cnt;
        repeat (20) step();
        check("release_out_low", out, 0);
        check("release_fall_cnt", fall_cnt - fb, 1);
        $display("clean release: out=%0b falls=%0d", out, fall_cnt - fb);

        for (int k = 0; k < 8; k++) begin
            if (div == 2'd2) break;
            step();
        end
        din = 1'b1;
        step();
        din = 1'b0;
        rb = rise_cnt;
        repeat (20) step();
        check("glitch_out", out, 0);
        check("glitch_rise_cnt", rise_cnt - rb, 0);
        $display("inter-sample glitch: out=%0b", out);

        for (int v = 0; v < 8; v++) begin
            logic [15:0] p;
            p  = vt[v].pat;
            rb = rise_cnt;
            fb = fall_cnt;
            for (int s = 0; s < vt[v].n; s++) begin
                din = p[s];
                repeat (4) step();
            end
            repeat (12) step();
            check("vec_out", out, vt[v].exp_out);
            check("vec_rise_cnt", rise_cnt - rb, vt[v].exp_rise);
            check("vec_fall_cnt", fall_cnt - fb, vt[v].exp_fall);
            $display("vector %0d: out=%0b rises=%0d falls=%0d", v, out, rise_cnt - rb, fall_cnt - fb);
        end

        din = 1'b0;
        repeat (24) step();
        din = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_res.run == 8'd2) begin
                n = 1;
                break;
            end
        end
        check("midqual_reached", n, 1);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (rise) begin
                n = i;
                break;
            end
        end
        check_rng("midqual_rise_latency", n, 11, 15);
        $display("reset mid-qualification: latency=%0d", n);

        din = 1'b0;
        repeat (24) step();
        div_en = 1'b0;
        din    = 1'b1;
        rb     = rise_cnt;
        repeat (30) step();
        check("frozen_out", out, 0);
        check("frozen_rise_cnt", rise_cnt - rb, 0);
        $display("frozen tick: out=%0b", out);
        div_en = 1'b1;
        din    = 1'b0;
        repeat (8) step();

        rb = rise_cnt;
        fb = fall_cnt;
        for (int g = 0; g < 120; g++) begin
            din = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 16));
            repeat (len) step();
        end
        repeat (20) step();
        $display("random: rises=%0d falls=%0d", rise_cnt - rb, fall_cnt - fb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
